// File: rtl/tdm_mux_8to1.sv
// Eight-lane round-robin merge onto one registered valid/ready output stage.
// out_sel tags each word with its source lane so a downstream 1:8 demux can route it back.
module tdm_mux_8to1 #(
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          ch_en,
    input  logic [7:0]          in_valid,
    input  logic [8*DATA_W-1:0] in_data,
    output logic [7:0]          in_ready,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    output logic [2:0]          out_sel,
    input  logic                out_ready,
    output logic                busy
);

    logic [2:0]        rr_ptr;
    logic [7:0]        req;
    logic              load_en;
    logic              grant_vld;
    logic [2:0]        grant;
    logic [2:0]        idx;
    logic [DATA_W-1:0] grant_word;

    assign req     = in_valid & ch_en;
    assign load_en = ~out_valid | out_ready;
    assign busy    = out_valid | (|req);

    // NOTE: every always_comb output gets a default first; a path that skips an assignment infers a latch.
    always_comb begin
        grant_vld = 1'b0;
        grant     = rr_ptr;
        idx       = rr_ptr;
        // Walk from the farthest lane back to rr_ptr so the nearest requester wins last.
        for (int k = 7; k >= 0; k--) begin
            idx = rr_ptr + 3'(k);
            if (req[idx]) begin
                grant_vld = 1'b1;
                grant     = idx;
            end
        end
    end

    always_comb begin
        grant_word = in_data[32'(grant)*DATA_W +: DATA_W];
    end

    // Gated by rst_n because the empty stage would otherwise advertise a grant during reset.
    always_comb begin
        in_ready = '0;
        if (rst_n && load_en && grant_vld) begin
            in_ready[grant] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            rr_ptr    <= '0;
        end else if (load_en) begin
            out_valid <= grant_vld;
            if (grant_vld) begin
                out_data <= grant_word;
                out_sel  <= grant;
                rr_ptr   <= grant + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_tdm_mux_8to1.sv
// Bench for tdm_mux_8to1: directed scenarios plus random loopback traffic,
// with a reference arbiter model and a scoreboard queue of accepted words.
module tb_tdm_mux_8to1;

    localparam int DATA_W = 8;

    typedef struct packed {
        logic [2:0] sel;
        logic [7:0] data;
    } word_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [7:0]          ch_en;
    logic [7:0]          in_valid;
    logic [8*DATA_W-1:0] in_data;
    logic [7:0]          in_ready;
    logic                out_valid;
    logic [DATA_W-1:0]   out_data;
    logic [2:0]          out_sel;
    logic                out_ready;
    logic                busy;

    int n_vec = 0;
    int n_err = 0;

    word_t      exp_q[$];
    logic       m_valid;
    logic [7:0] m_data;
    logic [2:0] m_sel;
    logic [2:0] m_ptr;
    logic [7:0] acc_mask = 8'h00;

    always #5 clk = ~clk;

    tdm_mux_8to1 #(.DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ch_en    (ch_en),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_sel  (out_sel),
        .out_ready(out_ready),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic set_lane(input int i, input logic [7:0] d);
        in_data[i*8 +: 8] = d;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [2:0] s, input logic [7:0] d);
        check({tag, "_valid"}, 32'(out_valid), 32'(v));
        check({tag, "_sel"},   32'(out_sel),   32'(s));
        check({tag, "_data"},  32'(out_data),  32'(d));
    endtask

    // Reference model, sampled one time unit before each rising edge.
    initial begin
        logic [7:0] req;
        logic [7:0] exp_rdy;
        logic [2:0] g;
        logic [2:0] idx;
        logic       found;
        logic       load;
        word_t      w;
        m_valid = 1'b0; m_data = '0; m_sel = '0; m_ptr = '0;
        forever begin
            @(negedge clk);
            #4;
            if (!rst_n) begin
                m_valid = 1'b0; m_data = '0; m_sel = '0; m_ptr = '0;
                exp_q.delete();
                acc_mask = 8'h00;
                check("rst_in_ready", 32'(in_ready), 32'h0);
            end else begin
                check("mon_valid", 32'(out_valid), 32'(m_valid));
                check("mon_sel",   32'(out_sel),   32'(m_sel));
                check("mon_data",  32'(out_data),  32'(m_data));
                req = in_valid & ch_en;
                check("mon_busy", 32'(busy), 32'(m_valid | (|req)));
                load  = !m_valid || out_ready;
                found = 1'b0;
                g     = 3'd0;
                for (int k = 0; k < 8; k++) begin
                    idx = m_ptr + 3'(k);
                    if (!found && req[idx]) begin
                        found = 1'b1;
                        g     = idx;
                    end
                end
                exp_rdy = (load && found) ? (8'd1 << g) : 8'd0;
                check("mon_in_ready", 32'(in_ready), 32'(exp_rdy));
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("sb_underflow", 32'(exp_q.size()), 32'd1);
                    end else begin
                        w = exp_q.pop_front();
                        check("loop_lane", 32'(out_sel),  32'(w.sel));
                        check("loop_data", 32'(out_data), 32'(w.data));
                    end
                end
                if (load) begin
                    m_valid = found;
                    if (found) begin
                        w.sel  = g;
                        w.data = in_data[32'(g)*8 +: 8];
                        exp_q.push_back(w);
                        m_data = w.data;
                        m_sel  = g;
                        m_ptr  = g + 3'd1;
                    end
                end
                acc_mask = exp_rdy;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic done;
        rst_n     = 1'b0;
        ch_en     = 8'hFF;
        in_valid  = 8'hFF;
        in_data   = '0;
        out_ready = 1'b0;
        #2;
        expect_out("reset", 1'b0, 3'd0, 8'h00);
        check("reset_in_ready", 32'(in_ready), 32'h0);
        @(negedge clk);
        in_valid = 8'h00;

        // Round-robin across all eight lanes.
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) set_lane(i, 8'(8'h10 + i));
        in_valid  = 8'hFF;
        out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            expect_out("rr", 1'b1, 3'(k % 8), 8'(8'h10 + (k % 8)));
        end
        in_valid = 8'h00;

        // Backpressure holding lane 2 while lane 3 waits.
        @(negedge clk);
        set_lane(2, 8'hA5);
        set_lane(3, 8'h3B);
        in_valid  = 8'b0000_1100;
        out_ready = 1'b0;
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            expect_out("bp_hold", 1'b1, 3'd2, 8'hA5);
            in_valid = 8'b0000_1000;
            #1;
            check("bp_in_ready", 32'(in_ready), 32'h0);
        end
        @(negedge clk);
        expect_out("bp_hold", 1'b1, 3'd2, 8'hA5);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'h08);
        @(negedge clk);
        expect_out("bp_next", 1'b1, 3'd3, 8'h3B);
        in_valid = 8'h00;

        // Steer rr_ptr to 6, then mask lane 7 and check the wrap to lane 0.
        @(negedge clk);
        set_lane(5, 8'h55);
        in_valid = 8'b0010_0000;
        @(negedge clk);
        set_lane(0, 8'h01);
        set_lane(7, 8'h77);
        in_valid = 8'b1000_0001;
        ch_en    = 8'b0111_1111;
        #1;
        check("wrap_ready", 32'(in_ready), 32'h01);
        @(negedge clk);
        expect_out("wrap", 1'b1, 3'd0, 8'h01);
        set_lane(0, 8'h02);
        set_lane(1, 8'h11);
        in_valid = 8'b1000_0011;
        #1;
        check("ptr_after_wrap", 32'(in_ready), 32'h02);
        @(negedge clk);
        expect_out("ptr_lane1", 1'b1, 3'd1, 8'h11);
        in_valid = 8'b1000_0001;
        #1;
        check("mask_lane7", 32'(in_ready), 32'h01);
        @(negedge clk);
        expect_out("mask_lane0", 1'b1, 3'd0, 8'h02);
        in_valid = 8'b1000_0000;
        #1;
        check("mask_idle_ready", 32'(in_ready), 32'h0);

        // Idle for two cycles, then a single lane.
        @(negedge clk);
        check("idle_valid", 32'(out_valid), 32'h0);
        check("idle_busy",  32'(busy),      32'h0);
        @(negedge clk);
        expect_out("idle_hold", 1'b0, 3'd0, 8'h02);
        check("idle_busy", 32'(busy), 32'h0);
        set_lane(6, 8'h3C);
        in_valid = 8'b1100_0000;
        #1;
        check("single_busy",  32'(busy),     32'h1);
        check("single_ready", 32'(in_ready), 32'h40);
        @(negedge clk);
        expect_out("single", 1'b1, 3'd6, 8'h3C);
        check("single_busy_out", 32'(busy), 32'h1);

        // Reset in the middle of a stream.
        set_lane(5, 8'h5F);
        in_valid = 8'b1010_0000;
        #1;
        check("pre_rst_ready", 32'(in_ready), 32'h20);
        @(negedge clk);
        expect_out("pre_rst", 1'b1, 3'd5, 8'h5F);
        in_valid  = 8'b1000_0000;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("mid_rst", 1'b0, 3'd0, 8'h00);
        check("mid_rst_ready", 32'(in_ready), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        set_lane(0, 8'hA0);
        set_lane(3, 8'hA3);
        in_valid  = 8'b1000_1001;
        out_ready = 1'b1;
        #1;
        check("post_rst_ready", 32'(in_ready), 32'h01);
        @(negedge clk);
        expect_out("post_rst0", 1'b1, 3'd0, 8'hA0);
        in_valid = 8'b1000_1000;
        @(negedge clk);
        expect_out("post_rst3", 1'b1, 3'd3, 8'hA3);
        in_valid = 8'b1000_0000;

        // Random loopback traffic; sources hold each word until accepted.
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                if (!in_valid[i] || acc_mask[i]) begin
                    in_valid[i] = ($urandom_range(0, 3) != 0);
                    set_lane(i, 8'($urandom));
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            if (c % 16 == 0) ch_en = 8'($urandom) | 8'h01;
        end

        ch_en     = 8'hFF;
        out_ready = 1'b1;
        done      = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            in_valid = in_valid & ~acc_mask;
            if (in_valid == 8'h00 && !out_valid) done = 1'b1;
        end
        check("drain_done", 32'(done), 32'h1);
        repeat (2) @(negedge clk);
        check("sb_leftover", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
